uart_tx_bridge: RTL and testbench

Bus-side sequencer that sits directly upstream of the UART register block and drives its control interface (configure/addr/data_in, read-back on data_out). It buffers CPU-supplied TX bytes in a FIFO and issues them to the UART data register only when the UART reports not-busy. Optionally it also drains received bytes into a holding register. The CPU never polls UART status itself.

---
 rtl/uart_bridge_pkg.sv | 30 +++
 rtl/uart_byte_fifo.sv | 51 +++++
 rtl/uart_tx_bridge.sv | 155 +++++++++++++++
 tb/tb_uart_tx_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART TX bridge: UART register map, status/control
// bit positions and the sequencer state encoding.
// Optional RX path is enabled by defining UART_BRIDGE_RX_EN.
package uart_bridge_pkg;

  localparam logic [31:0] UART_CTRL = 32'h00;
  localparam logic [31:0] UART_STAT = 32'h04;
  localparam logic [31:0] UART_TXD  = 32'h0C;
  localparam logic [31:0] UART_RXD  = 32'h10;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int STAT_TX_BUSY = 0;
  localparam int STAT_RX_DONE = 1;

  typedef enum logic [2:0] {
    INIT, POLL_A, POLL_S, TX_WR, SETTLE_W
`ifdef UART_BRIDGE_RX_EN
    , RX_A, RX_S, RX_CLR
`endif
  } state_t;

  // One cycle worth of UART control-interface drive.
  typedef struct packed {
    logic        cfg;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ubus_req_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// DEPTH x 8 synchronous FIFO; head is visible on dout while not empty.
// Pushes while full and pops while empty are ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// Sequencer in front of the UART register block: queues CPU TX bytes and
// writes them to the UART data register whenever status reports not-busy.
// Define UART_BRIDGE_RX_EN to also drain received bytes into rx_data.
// Bus outputs are decoded from registered state only (never from u_rdata).
module uart_tx_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 4
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     push_valid,
  input  logic [7:0]               push_data,
  output logic                     push_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     u_configure,
  output logic [31:0]              u_addr,
  output logic [31:0]              u_wdata,
  input  logic [31:0]              u_rdata
`ifdef UART_BRIDGE_RX_EN
  ,
  output logic                     rx_valid,
  output logic [7:0]               rx_data,
  input  logic                     rx_ready
`endif
);

  localparam int SW = $clog2(SETTLE) + 1;
`ifdef UART_BRIDGE_RX_EN
  localparam logic [31:0] CTRL_WORD = (32'h1 << CTRL_TX_EN) | (32'h1 << CTRL_RX_EN);
`else
  localparam logic [31:0] CTRL_WORD = (32'h1 << CTRL_TX_EN);
`endif

  state_t        state, state_nxt;
  ubus_req_t     req;
  logic          run;
  logic [SW-1:0] settle_cnt;
  logic          pop, full, empty;
  logic [7:0]    head;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .srst_n (srst_n),
    .push   (push_valid),
    .din    (push_data),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign push_ready  = !full;
  assign u_configure = req.cfg;
  assign u_addr      = req.addr;
  assign u_wdata     = req.wdata;

`ifdef UART_BRIDGE_RX_EN
  logic unused_rdata;
  assign unused_rdata = ^u_rdata[31:8];
`else
  logic unused_rdata;
  assign unused_rdata = ^u_rdata[31:1];
`endif

  // State register; run holds INIT silent until the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= INIT;
      run        <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      run        <= 1'b1;
      settle_cnt <= (state == SETTLE_W) ? settle_cnt + 1'b1 : '0;
    end
  end

  // Next-state and bus drive decode.
  always_comb begin
    state_nxt = state;
    req       = '0;
    pop       = 1'b0;
    case (state)
      INIT: begin
        if (run) begin
          req.cfg   = 1'b1;
          req.addr  = UART_CTRL;
          req.wdata = CTRL_WORD;
          state_nxt = POLL_A;
        end
      end
      POLL_A: begin
        req.addr  = UART_STAT;
        state_nxt = POLL_S;
      end
      POLL_S: begin
        req.addr = UART_STAT;
`ifdef UART_BRIDGE_RX_EN
        if (u_rdata[STAT_RX_DONE] && !rx_valid)
          state_nxt = RX_A;
        else
`endif
        if (!u_rdata[STAT_TX_BUSY] && !empty)
          state_nxt = TX_WR;
        else
          state_nxt = POLL_A;
      end
      TX_WR: begin
        req.cfg   = 1'b1;
        req.addr  = UART_TXD;
        req.wdata = {24'b0, head};
        pop       = 1'b1;
        state_nxt = SETTLE_W;
      end
      SETTLE_W: begin
        if (settle_cnt == SW'(SETTLE - 1)) state_nxt = POLL_A;
      end
`ifdef UART_BRIDGE_RX_EN
      RX_A: begin
        req.addr  = UART_RXD;
        state_nxt = RX_S;
      end
      RX_S: begin
        req.addr  = UART_RXD;
        state_nxt = RX_CLR;
      end
      RX_CLR: begin
        req.cfg   = 1'b1;
        req.addr  = UART_STAT;
        state_nxt = POLL_A;
      end
`endif
      default: state_nxt = INIT;
    endcase
  end

`ifdef UART_BRIDGE_RX_EN
  // RX holding register; RX-done stays set upstream while rx_valid is held.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else if (state == RX_S) begin
      rx_valid <= 1'b1;
      rx_data  <= u_rdata[7:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge with a small UART register model.
// RX checks are compiled only when UART_BRIDGE_RX_EN is defined.
module tb_uart_tx_bridge;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 4;
`ifdef UART_BRIDGE_RX_EN
  localparam logic [31:0] CTRL_EXP = 32'h3;
`else
  localparam logic [31:0] CTRL_EXP = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [7:0]  push_data = 8'h00;
  logic        push_ready;
  logic [4:0]  fifo_count;
  logic        u_configure;
  logic [31:0] u_addr, u_wdata, u_rdata;
`ifdef UART_BRIDGE_RX_EN
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_bridge #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .fifo_count  (fifo_count),
    .u_configure (u_configure),
    .u_addr      (u_addr),
    .u_wdata     (u_wdata),
    .u_rdata     (u_rdata)
`ifdef UART_BRIDGE_RX_EN
    ,
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready)
`endif
  );

  // UART model: registered read-back, write log, RX-done flag cleared by a write to status.
  logic        busy = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  int          rx_arm = 0;
  int          rx_seen = 0;
  int          rxd_reads = 0;
  int          cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wt_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!srst_n) begin
      rx_done <= 1'b0;
      u_rdata <= '0;
      rx_seen <= rx_arm;
    end else begin
      case (u_addr)
        32'h04:  u_rdata <= {30'b0, rx_done, busy};
        32'h10:  u_rdata <= {24'b0, rx_byte};
        default: u_rdata <= '0;
      endcase
      if (u_configure) begin
        wa_q.push_back(u_addr);
        wd_q.push_back(u_wdata);
        wt_q.push_back(cyc);
      end
      if (u_configure && u_addr == 32'h04) rx_done <= 1'b0;
      else if (rx_arm != rx_seen) begin
        rx_done <= 1'b1;
        rx_seen <= rx_arm;
      end
      if (!u_configure && u_addr == 32'h10) rxd_reads <= rxd_reads + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int b = 0;
    while (wa_q.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_timeout"}, 32'(wa_q.size() >= n), 32'd1);
  endtask

  task automatic push(input logic [7:0] d, output logic acc);
    push_valid = 1'b1;
    push_data  = d;
    acc        = push_ready;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   nacc;
    int   base;

    // Reset values while srst_n is held low.
    repeat (3) @(negedge clk);
    chk("rst_cfg",   32'(u_configure), 32'd0);
    chk("rst_addr",  u_addr,           32'd0);
    chk("rst_wdata", u_wdata,          32'd0);
    chk("rst_ready", 32'(push_ready),  32'd1);
    chk("rst_count", 32'(fifo_count),  32'd0);
`ifdef UART_BRIDGE_RX_EN
    chk("rst_rxv",   32'(rx_valid),    32'd0);
    chk("rst_rxd",   32'(rx_data),     32'd0);
`endif

    // First bus cycle after release is the control write.
    srst_n = 1'b1;
    wait_wr(1, 10, "init");
    chk("init_addr", wa_q[0], 32'h00);
    chk("init_data", wd_q[0], CTRL_EXP);

    // Single byte with the UART idle, then a second to measure spacing.
    push(8'h41, acc);
    chk("push41_acc",   32'(acc),        32'd1);
    chk("push41_count", 32'(fifo_count), 32'd1);
    wait_wr(2, 30, "tx41");
    chk("tx41_addr",  wa_q[1], 32'h0C);
    chk("tx41_data",  wd_q[1], 32'h41);
    chk("tx41_count", 32'(fifo_count), 32'd0);
    push(8'h42, acc);
    wait_wr(3, 30, "tx42");
    chk("tx42_data",    wd_q[2], 32'h42);
    chk("tx42_spacing", 32'(wt_q[2] - wt_q[1]), 32'(SETTLE + 3));

    // Fill past DEPTH while busy; the extra byte must be dropped.
    busy = 1'b1;
    nacc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(8'h10 + 8'(i), acc);
      if (acc) nacc++;
    end
    chk("full_last_acc", 32'(acc),        32'd0);
    chk("full_naccept",  32'(nacc),       32'(DEPTH));
    chk("full_count",    32'(fifo_count), 32'(DEPTH));
    chk("full_ready",    32'(push_ready), 32'd0);
    chk("full_no_wr",    32'(wa_q.size()), 32'd3);
    busy = 1'b0;
    wait_wr(3 + DEPTH, DEPTH * 12 + 40, "drain");
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain_addr%0d", i), wa_q[3 + i], 32'h0C);
      chk($sformatf("drain_data%0d", i), wd_q[3 + i], 32'h10 + 32'(i));
    end
    repeat (30) @(negedge clk);
    chk("drain_total", 32'(wa_q.size()), 32'(3 + DEPTH));
    chk("drain_count", 32'(fifo_count),  32'd0);

    // Reset during SETTLE_W with three bytes still queued.
    base = wa_q.size();
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i), acc);
    busy = 1'b0;
    wait_wr(base + 1, 40, "rst_pre");
    chk("rst_pre_data",  wd_q[base], 32'h61);
    chk("rst_pre_count", 32'(fifo_count), 32'd3);
    srst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_cfg",   32'(u_configure), 32'd0);
    chk("rst_mid_count", 32'(fifo_count),  32'd0);
    srst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_post_nwr",  32'(wa_q.size()), 32'(base + 2));
    chk("rst_post_addr", wa_q[base + 1], 32'h00);
    chk("rst_post_data", wd_q[base + 1], CTRL_EXP);
    chk("rst_post_rdy",  32'(push_ready), 32'd1);

`ifdef UART_BRIDGE_RX_EN
    // RX done with a TX byte pending: read, clear, then the TX write.
    base = wa_q.size();
    busy = 1'b1;
    push(8'h77, acc);
    rx_byte = 8'h5A;
    rx_arm++;
    repeat (3) @(negedge clk);
    busy = 1'b0;
    wait_wr(base + 2, 40, "rx1");
    chk("rx1_valid",  32'(rx_valid), 32'd1);
    chk("rx1_data",   32'(rx_data),  32'h5A);
    chk("rx1_clr_a",  wa_q[base],     32'h04);
    chk("rx1_clr_d",  wd_q[base],     32'h00);
    chk("rx1_tx_a",   wa_q[base + 1], 32'h0C);
    chk("rx1_tx_d",   wd_q[base + 1], 32'h77);

    // Backpressure: no RX data read while rx_valid is held.
    base = rxd_reads;
    rx_byte = 8'h33;
    rx_arm++;
    repeat (20) @(negedge clk);
    chk("rx2_noread", 32'(rxd_reads), 32'(base));
    chk("rx2_hold",   32'(rx_data),   32'h5A);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx2_clear",  32'(rx_valid), 32'd0);
    begin
      int b = 0;
      while (!rx_valid && b < 30) begin
        @(negedge clk);
        b++;
      end
    end
    chk("rx2_valid", 32'(rx_valid), 32'd1);
    chk("rx2_data",  32'(rx_data),  32'h33);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
